// File: rtl/ac_upsp_bridge.sv
// Access-controller bridge: source reads -> upsampler input stream, upsampler output -> FIFO -> destination.
// Optional output checksum on frame_sum is built when AC_FRAME_SUM_EN is defined.
module ac_upsp_bridge #(
  parameter int unsigned DW         = 24,
  parameter int unsigned SRC_W      = 960,
  parameter int unsigned SRC_H      = 540,
  parameter int unsigned SCALE      = 4,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          src_ren,
  output logic [31:0]   src_raddr,
  input  logic [DW-1:0] src_rdata,
  input  logic          upsp_ac_rready,
  output logic [DW-1:0] ac_upsp_rdata,
  output logic          ac_upsp_rvalid,
  input  logic [DW-1:0] upsp_ac_wdata,
  input  logic          upsp_ac_wvalid,
  output logic          ac_upsp_wready,
  output logic [DW-1:0] dst_wdata,
  output logic          dst_wvalid,
  input  logic          dst_wready,
  output logic [31:0]   frame_sum
);

  localparam int unsigned NPIX = SRC_W * SRC_H;
  localparam int unsigned NOUT = NPIX * SCALE * SCALE;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   issue_cnt, in_cnt, out_cnt;
  logic          rd_pend;
  logic [DW-1:0] skid0, skid1;
  logic [1:0]    skid_occ;
  logic [1:0]    skid_slot;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          fifo_full, fifo_empty;
  logic          start_frame, in_xfer, push, pop, src_ren_c;

  assign start_frame = (state == S_IDLE) && start;
  assign fifo_empty  = (wp == rp);
  assign fifo_full   = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  assign ac_upsp_rvalid = (skid_occ != 2'd0);
  assign ac_upsp_rdata  = skid0;
  assign in_xfer        = ac_upsp_rvalid && upsp_ac_rready;

  // The entry leaving this cycle frees a slot, which keeps the read path at one pixel per cycle.
  assign src_ren_c = (state == S_FEED) && (issue_cnt < 32'(NPIX)) &&
                     ((3'(skid_occ) + 3'(rd_pend)) < (3'd2 + 3'(in_xfer)));
  assign src_ren   = src_ren_c;
  assign src_raddr = issue_cnt;
  assign skid_slot = skid_occ - 2'(in_xfer);

  assign ac_upsp_wready = !fifo_full && ((state == S_FEED) || (state == S_DRAIN));
  assign push           = upsp_ac_wvalid && ac_upsp_wready;
  assign dst_wvalid     = !fifo_empty;
  assign dst_wdata      = fifo_empty ? '0 : mem[rp[AW-1:0]];
  assign pop            = dst_wvalid && dst_wready;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Frame sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FEED;
      S_FEED:  if (in_xfer && (in_cnt == 32'(NPIX - 1))) state_nxt = S_DRAIN;
      S_DRAIN: if ((out_cnt == 32'(NOUT)) || (pop && (out_cnt == 32'(NOUT - 1))))
                 state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, skid buffer and FIFO pointers; a new frame starts from a clean slate
  always_ff @(posedge clk) begin
    if (rst || start_frame) begin
      issue_cnt <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      rd_pend   <= 1'b0;
      skid_occ  <= '0;
      skid0     <= '0;
      skid1     <= '0;
      wp        <= '0;
      rp        <= '0;
    end else begin
      rd_pend  <= src_ren_c;
      skid_occ <= skid_occ + 2'(rd_pend) - 2'(in_xfer);
      if (src_ren_c) issue_cnt <= issue_cnt + 32'd1;
      if (in_xfer) begin
        in_cnt <= in_cnt + 32'd1;
        skid0  <= skid1;
      end
      // Returning read data lands behind whatever is still queued
      if (rd_pend) begin
        if (skid_slot == 2'd0) skid0 <= src_rdata;
        else                   skid1 <= src_rdata;
      end
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) begin
        rp      <= rp + (AW+1)'(1);
        out_cnt <= out_cnt + 32'd1;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= upsp_ac_wdata;
  end

`ifdef AC_FRAME_SUM_EN
  logic [31:0] sum_q;

  // Checksum of every pixel leaving the block, held until the next start
  always_ff @(posedge clk) begin
    if (rst || start_frame) sum_q <= '0;
    else if (pop)           sum_q <= sum_q + 32'(dst_wdata);
  end

  assign frame_sum = sum_q;
`else
  assign frame_sum = '0;
`endif

endmodule
